// File: rtl/fft_stage_sequencer.sv
// Control sequencer for an in-place radix-2 DIT FFT: walks every stage, issues
// butterfly read/twiddle addresses and delays them to form the write-back stream.
module fft_stage_sequencer #(
    parameter int N_LOG2 = 9,
    parameter int BF_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fft_start,
    input  logic              bfly_ready,
    output logic              issue_valid,
    output logic [N_LOG2-1:0] rd_addr_a,
    output logic [N_LOG2-1:0] rd_addr_b,
    output logic [N_LOG2-2:0] twiddle_idx,
    output logic              wr_valid,
    output logic [N_LOG2-1:0] wr_addr_a,
    output logic [N_LOG2-1:0] wr_addr_b,
    output logic [3:0]        stage,
    output logic              busy,
    output logic              fft_done
);

    localparam int KW = N_LOG2 - 1;
    localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(BF_LAT - 1);
    localparam logic [3:0]        LAST_STAGE = 4'(N_LOG2 - 1);
    localparam logic [N_LOG2-1:0] ONE        = N_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      stage_reg, stage_next;
    logic [KW-1:0]   k_reg, k_next;
    logic [DW-1:0]   drain_reg, drain_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            stage_reg <= '0;
            k_reg     <= '0;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            stage_reg <= stage_next;
            k_reg     <= k_next;
            drain_reg <= drain_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        stage_next  = stage_reg;
        k_next      = k_reg;
        drain_next  = drain_reg;
        issue_valid = 1'b0;
        busy        = 1'b0;
        fft_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fft_start) begin
                    state_next = ISSUE;
                    stage_next = '0;
                    k_next     = '0;
                end
            end
            ISSUE: begin
                busy        = 1'b1;
                issue_valid = bfly_ready;
                if (bfly_ready) begin
                    k_next = k_reg + KW'(1);
                    if (k_reg == {KW{1'b1}}) begin
                        state_next = DRAIN;
                        drain_next = '0;
                    end
                end
            end
            DRAIN: begin
                // Next stage may only read once the last write of this one has landed.
                busy = 1'b1;
                if (drain_reg == DRAIN_LAST) begin
                    if (stage_reg < LAST_STAGE) begin
                        stage_next = stage_reg + 4'd1;
                        k_next     = '0;
                        state_next = ISSUE;
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    drain_next = drain_reg + DW'(1);
                end
            end
            DONE: begin
                fft_done   = 1'b1;
                stage_next = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Butterfly k of stage s pairs x[a] with x[a+2^s], a = k with a zero inserted at bit s.
    logic [N_LOG2-1:0] k_ext, span, low, addr_a_calc, addr_b_calc, tw_calc;

    always_comb begin
        k_ext       = {1'b0, k_reg};
        span        = ONE << stage_reg;
        low         = k_ext & (span - ONE);
        addr_a_calc = ((k_ext >> stage_reg) << (stage_reg + 4'd1)) | low;
        addr_b_calc = addr_a_calc + span;
        tw_calc     = low << (LAST_STAGE - stage_reg);
    end

    assign rd_addr_a   = (state_reg == ISSUE) ? addr_a_calc : '0;
    assign rd_addr_b   = (state_reg == ISSUE) ? addr_b_calc : '0;
    assign twiddle_idx = (state_reg == ISSUE) ? tw_calc[KW-1:0] : '0;
    assign stage       = stage_reg;

    // Write-back delay line: free-running, so write timing never depends on back-pressure.
    genvar gi;
    generate
        for (gi = 0; gi < BF_LAT; gi++) begin : g_wr_pipe
            logic              v_reg;
            logic [N_LOG2-1:0] a_reg;
            logic [N_LOG2-1:0] b_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        v_reg <= 1'b0;
                        a_reg <= '0;
                        b_reg <= '0;
                    end else begin
                        v_reg <= issue_valid;
                        a_reg <= rd_addr_a;
                        b_reg <= rd_addr_b;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        v_reg <= 1'b0;
                        a_reg <= '0;
                        b_reg <= '0;
                    end else begin
                        v_reg <= g_wr_pipe[gi-1].v_reg;
                        a_reg <= g_wr_pipe[gi-1].a_reg;
                        b_reg <= g_wr_pipe[gi-1].b_reg;
                    end
                end
            end
        end
    endgenerate

    assign wr_valid  = g_wr_pipe[BF_LAT-1].v_reg;
    assign wr_addr_a = g_wr_pipe[BF_LAT-1].a_reg;
    assign wr_addr_b = g_wr_pipe[BF_LAT-1].b_reg;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: a cycle-level reference built from the FFT
// butterfly enumeration, driven with full-rate and random back-pressure runs.
module tb_fft_stage_sequencer;

    localparam int N_LOG2  = 9;
    localparam int BF_LAT  = 3;
    localparam int NB      = 256;
    localparam int NISSUE  = 9 * NB;
    localparam int MAX_CYC = 12000;

    logic       tb_clk = 1'b0;
    logic       rst;
    logic       fft_start;
    logic       bfly_ready;
    logic       issue_valid;
    logic [8:0] rd_addr_a;
    logic [8:0] rd_addr_b;
    logic [7:0] twiddle_idx;
    logic       wr_valid;
    logic [8:0] wr_addr_a;
    logic [8:0] wr_addr_b;
    logic [3:0] stage;
    logic       busy;
    logic       fft_done;

    fft_stage_sequencer #(.N_LOG2(N_LOG2), .BF_LAT(BF_LAT)) dut (
        .clk         (tb_clk),
        .rst         (rst),
        .fft_start   (fft_start),
        .bfly_ready  (bfly_ready),
        .issue_valid (issue_valid),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .twiddle_idx (twiddle_idx),
        .wr_valid    (wr_valid),
        .wr_addr_a   (wr_addr_a),
        .wr_addr_b   (wr_addr_b),
        .stage       (stage),
        .busy        (busy),
        .fft_done    (fft_done)
    );

    always #5 tb_clk = ~tb_clk;

    int checks   = 0;
    int failures = 0;

    // Reference butterfly list, in issue order
    int exp_a [NISSUE];
    int exp_b [NISSUE];
    int exp_tw[NISSUE];
    // Observed issues of the most recent run, in issue order
    int obs_a [NISSUE];
    int obs_b [NISSUE];
    int obs_tw[NISSUE];

    typedef struct {
        int cyc;
        int a;
        int b;
    } wr_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
            if (failures >= 50) begin
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    endtask

    task automatic build_reference();
        int n = 0;
        for (int s = 0; s < 9; s++) begin
            int span = 1 << s;
            for (int g = 0; g < 512 / (2 * span); g++) begin
                for (int j = 0; j < span; j++) begin
                    exp_a[n]  = g * 2 * span + j;
                    exp_b[n]  = exp_a[n] + span;
                    exp_tw[n] = j * (256 / span);
                    n++;
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_issue_valid"}, issue_valid, 0);
        chk({tag, "_rd_addr_a"}, rd_addr_a, 0);
        chk({tag, "_rd_addr_b"}, rd_addr_b, 0);
        chk({tag, "_twiddle_idx"}, twiddle_idx, 0);
        chk({tag, "_wr_valid"}, wr_valid, 0);
        chk({tag, "_wr_addr_a"}, wr_addr_a, 0);
        chk({tag, "_wr_addr_b"}, wr_addr_b, 0);
        chk({tag, "_stage"}, stage, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fft_done"}, fft_done, 0);
    endtask

    // One transform. rand_ready: 50% back-pressure; hold_start: keep fft_start high;
    // pulse_stage: extra start pulse inside that stage; abort_stage: assert rst there.
    task automatic run_fft(input bit rand_ready, input bit hold_start,
                           input int pulse_stage, input int abort_stage);
        int  idx = 0;
        int  drain = 0;
        int  iss_cnt = 0;
        int  wr_cnt = 0;
        bit  finished = 0;
        bit  aborted = 0;
        bit  pulsed = 0;
        bit  r;
        bit  exp_w;
        int  touch[9*512];
        wr_t pend_q[$];
        wr_t w;

        foreach (touch[i]) touch[i] = 0;

        @(posedge tb_clk); #1;
        fft_start  = 1'b1;
        bfly_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        chk("idle_busy_before_start", busy, 0);

        for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
            @(posedge tb_clk); #1;
            r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bfly_ready = r;
            fft_start  = hold_start;
            if (pulse_stage >= 0 && !pulsed && drain == 0 && idx < NISSUE &&
                idx / NB == pulse_stage && idx % NB == 50) begin
                fft_start = 1'b1;
                pulsed    = 1'b1;
            end
            if (abort_stage >= 0 && drain == 0 && idx == abort_stage * NB + 100) begin
                rst = 1'b1;
                #1;
                check_all_zero("abort_reset");
                aborted = 1'b1;
                break;
            end
            #1;

            if (idx == NISSUE && drain == 0) begin
                chk("done_pulse", fft_done, 1);
                chk("done_busy_low", busy, 0);
                chk("done_no_issue", issue_valid, 0);
                chk("done_no_write", wr_valid, 0);
                if (!rand_ready) chk("done_cycle", cyc, 9 * (NB + BF_LAT) + 1);
                finished = 1'b1;
                break;
            end

            chk("no_early_done", fft_done, 0);
            chk("busy_high", busy, 1);
            if (drain > 0) begin
                chk("drain_no_issue", issue_valid, 0);
                chk("drain_stage", stage, (idx - 1) / NB);
                drain--;
            end else begin
                chk("issue_valid", issue_valid, r);
                chk("rd_addr_a", rd_addr_a, exp_a[idx]);
                chk("rd_addr_b", rd_addr_b, exp_b[idx]);
                chk("twiddle_idx", twiddle_idx, exp_tw[idx]);
                chk("issue_stage", stage, idx / NB);
                if (r) begin
                    w.cyc = cyc + BF_LAT;
                    w.a   = exp_a[idx];
                    w.b   = exp_b[idx];
                    pend_q.push_back(w);
                    idx++;
                    if (idx % NB == 0) drain = BF_LAT;
                end
            end

            exp_w = (pend_q.size() > 0) && (pend_q[0].cyc == cyc);
            chk("wr_valid", wr_valid, exp_w);
            if (exp_w) begin
                w = pend_q.pop_front();
                chk("wr_addr_a", wr_addr_a, w.a);
                chk("wr_addr_b", wr_addr_b, w.b);
            end

            if (issue_valid === 1'b1 && iss_cnt < NISSUE && stage < 9) begin
                obs_a[iss_cnt]  = rd_addr_a;
                obs_b[iss_cnt]  = rd_addr_b;
                obs_tw[iss_cnt] = twiddle_idx;
                touch[stage * 512 + rd_addr_a]++;
                touch[stage * 512 + rd_addr_b]++;
                iss_cnt++;
            end
            if (wr_valid === 1'b1) wr_cnt++;
        end

        chk("run_completed", finished | aborted, 1);
        if (finished) begin
            int bad;
            chk("issue_count", iss_cnt, NISSUE);
            chk("write_count", wr_cnt, NISSUE);
            chk("pending_writes", pend_q.size(), 0);
            for (int s = 0; s < 9; s++) begin
                bad = 0;
                for (int a = 0; a < 512; a++) if (touch[s * 512 + a] != 1) bad++;
                chk($sformatf("stage%0d_coverage_bad", s), bad, 0);
            end
        end
        $display("run rand_ready=%0d hold=%0d pulse_stage=%0d abort_stage=%0d issues=%0d writes=%0d done=%0d",
                 rand_ready, hold_start, pulse_stage, abort_stage, iss_cnt, wr_cnt, finished);
    endtask

    // Idle observation window: counts any activity that must not happen.
    task automatic idle_watch(input int ncyc, input string tag);
        int act_issue = 0;
        int act_wr = 0;
        int act_done = 0;
        int act_busy = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge tb_clk); #2;
            if (issue_valid !== 1'b0) act_issue++;
            if (wr_valid !== 1'b0) act_wr++;
            if (fft_done !== 1'b0) act_done++;
            if (busy !== 1'b0) act_busy++;
        end
        chk({tag, "_issue_cycles"}, act_issue, 0);
        chk({tag, "_wr_cycles"}, act_wr, 0);
        chk({tag, "_done_cycles"}, act_done, 0);
        chk({tag, "_busy_cycles"}, act_busy, 0);
    endtask

    initial begin
        rst        = 1'b1;
        fft_start  = 1'b0;
        bfly_ready = 1'b0;
        build_reference();

        repeat (3) @(posedge tb_clk);
        #2;
        check_all_zero("reset");
        rst = 1'b0;

        // Full-rate transform plus directed address points
        run_fft(1'b0, 1'b0, -1, -1);
        fft_start = 1'b0;
        chk("s0_k0_a", obs_a[0], 0);
        chk("s0_k0_b", obs_b[0], 1);
        chk("s0_k0_tw", obs_tw[0], 0);
        chk("s0_k1_a", obs_a[1], 2);
        chk("s0_k1_b", obs_b[1], 3);
        chk("s0_k2_a", obs_a[2], 4);
        chk("s0_k2_b", obs_b[2], 5);
        chk("s3_k9_a", obs_a[3 * NB + 9], 17);
        chk("s3_k9_b", obs_b[3 * NB + 9], 25);
        chk("s3_k9_tw", obs_tw[3 * NB + 9], 32);
        chk("s8_k255_a", obs_a[8 * NB + 255], 255);
        chk("s8_k255_b", obs_b[8 * NB + 255], 511);
        chk("s8_k255_tw", obs_tw[8 * NB + 255], 255);

        // Random back-pressure
        run_fft(1'b1, 1'b0, -1, -1);
        fft_start = 1'b0;

        // Extra start in stage 4 must be ignored: only one done, then silence
        run_fft(1'b1, 1'b0, 4, -1);
        fft_start = 1'b0;
        idle_watch(300, "after_single_done");

        // fft_start held high: back-to-back transforms
        run_fft(1'b0, 1'b1, -1, -1);
        run_fft(1'b0, 1'b1, -1, -1);
        fft_start = 1'b0;
        idle_watch(20, "after_back_to_back");

        // Reset during stage 5 aborts; then a full transform must still work
        run_fft(1'b1, 1'b0, -1, 5);
        fft_start = 1'b0;
        repeat (2) @(posedge tb_clk);
        #1;
        rst = 1'b0;
        idle_watch(50, "after_abort");
        run_fft(1'b1, 1'b0, -1, -1);
        fft_start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Control block for the in-place 512-point radix-2 DIT FFT.
- Sequences all 9 butterfly stages: on `fft_start` it generates read addresses and twiddle indices for every butterfly and issues them to the pipelined butterfly unit.
- Tracks the write-back addresses through the butterfly latency and separates stages so no read overtakes a pending write.
- Pulses `fft_done` when the transform is complete. Input bit-reversal and data loading are done upstream.

Parameters:
- N_LOG2, 9, log2 of FFT length; 9 stages, 2^(N_LOG2-1)=256 butterflies per stage.
- BF_LAT, 3, butterfly pipeline latency in cycles from issue to write-back (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fft_start  in  1  start request; sampled only in IDLE.
- bfly_ready  in  1  butterfly unit can accept an issue this cycle.
- issue_valid  out  1  butterfly issued this cycle.
- rd_addr_a  out  N_LOG2  top operand address.
- rd_addr_b  out  N_LOG2  bottom operand address.
- twiddle_idx  out  N_LOG2-1  twiddle ROM index.
- wr_valid  out  1  write-back strobe, BF_LAT cycles after the matching issue.
- wr_addr_a  out  N_LOG2  write address for the top result.
- wr_addr_b  out  N_LOG2  write address for the bottom result.
- stage  out  4  current stage number, 0..N_LOG2-1.
- busy  out  1  high from the start-sampling edge until DONE is entered.
- fft_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: asynchronous, active-high. All outputs are 0. FSM goes to IDLE; stage, butterfly and drain counters clear; the write pipeline is flushed (wr_valid=0 on every stage). Reset mid-transform aborts it: no fft_done is produced and no further writes occur.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE -> ISSUE on a clock edge with fft_start=1. Stage=0, butterfly counter k=0, busy=1 from that edge.
- ISSUE:
  - issue_valid = bfly_ready (combinational from the registered state).
  - Address decode uses s=stage, span=2^s:
    - rd_addr_a = ((k>>s)<<(s+1)) | (k & (span-1))
    - rd_addr_b = rd_addr_a + span
    - twiddle_idx = (k & (span-1)) << (N_LOG2-1-s)
  - k increments only on issue_valid.
  - When k=255 and issue_valid=1: go to DRAIN with drain counter=0.
  - bfly_ready=0 holds k and addresses stable (no issue, no skip).
- DRAIN:
  - Lasts exactly BF_LAT cycles, ignoring bfly_ready. The final stage write lands in the last DRAIN cycle.
  - On exit: if stage < N_LOG2-1, increment stage, k=0, go to ISSUE. Otherwise go to DONE.
- DONE: fft_done=1 and busy=0 for exactly one cycle, then IDLE.
- Write pipeline:
  - BF_LAT-deep register chain of {issue_valid, rd_addr_a, rd_addr_b}.
  - wr_valid/wr_addr_a/wr_addr_b are the chain output, so an issue in cycle c appears as a write in cycle c+BF_LAT.
  - The chain advances every cycle, independent of bfly_ready.
- fft_start while busy or in DONE is ignored; no queuing.
- fft_start held high continuously: a new transform starts on the first edge in IDLE after DONE.
- stage holds its value in DRAIN. It returns to 0 on entering IDLE.
- Arithmetic is unsigned. rd_addr_b never exceeds 2^N_LOG2-1, and no addresses wrap.
- Latency with bfly_ready held high:
  - Each stage takes 256 + BF_LAT cycles.
  - fft_done is high in cycle 9*(256+BF_LAT)+1 after the start-sampling edge; that is cycle 2332 for BF_LAT=3.
  - Total issues = 2304; total wr_valid cycles = 2304.

Test Plan:
- Reset, then fft_start pulse with bfly_ready=1:
  - Stage 0, k=0..2: (a,b,tw) = (0,1,0), (2,3,0), (4,5,0).
  - fft_done lands in cycle 2332; busy drops on the same cycle; exactly 2304 issue_valid and 2304 wr_valid.
- Stage address checks:
  - Stage 3, k=9 -> rd_addr_a=17, rd_addr_b=25, twiddle_idx=32.
  - Stage 8, k=255 -> (255, 511, 255).
  - Scoreboard confirms each stage touches all 512 addresses exactly once.
- Write alignment:
  - Every wr_valid carries the addresses issued exactly 3 cycles earlier.
  - No rd of stage s+1 occurs before the last wr of stage s.
- Back-pressure: random bfly_ready at 50% duty.
  - Addresses hold while ready is low; issue sequence is identical to the ready=1 run.
  - fft_done arrives 2304 ready-high issue cycles plus 27 drain cycles plus 1 after start.
- fft_start pulsed again mid-stage 4 -> ignored; one fft_done only. fft_start held high -> back-to-back transforms, each with its own fft_done.
- Assert rst in stage 5 -> all outputs 0 immediately, wr_valid stays 0 afterwards, no fft_done. A subsequent fft_start runs a full correct transform.
